// File: rtl/iteration_sync_ctrl_pkg.sv
// Shared defaults and state encoding for the global iteration sequencer.
// Also hosts the busy-state decode used by the controller.
package iteration_sync_ctrl_pkg;

   localparam int CORE_NUM_DEF          = 4;
   localparam int ITERATION_WIDTH_DEF   = 8;
   localparam int MAX_ITERATION_NUM_DEF = 16;
   localparam int UPD_CNT_WIDTH_DEF     = 32;
   localparam int DRAIN_CYCLES_DEF      = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_DRAIN   = 3'd2,
      ST_ADVANCE = 3'd3,
      ST_DONE    = 3'd4
   } sync_state_e;

   function automatic logic is_busy_state(input sync_state_e st);
      return (st == ST_RUN) || (st == ST_DRAIN) || (st == ST_ADVANCE);
   endfunction

endpackage

// File: rtl/iteration_sync_ctrl_if.sv
// Per-core signal bundle between the active-vertex readers and the iteration sequencer.
// master = core side, slave = sequencer side.
interface iteration_sync_ctrl_if #(
   parameter int CORE_NUM = 4
);

   logic [CORE_NUM-1:0] core_iter_end;
   logic [CORE_NUM-1:0] core_upd_valid;
   logic [CORE_NUM-1:0] core_upd;
   logic [CORE_NUM-1:0] pipe_idle;
   logic [CORE_NUM-1:0] iter_advance;

   modport master (
      output core_iter_end,
      output core_upd_valid,
      output core_upd,
      output pipe_idle,
      input  iter_advance
   );

   modport slave (
      input  core_iter_end,
      input  core_upd_valid,
      input  core_upd,
      input  pipe_idle,
      output iter_advance
   );

endinterface

// File: rtl/iteration_sync_ctrl_popcount_tree.sv
// Combinational popcount built as a recursive balanced adder tree.
// Also used for active-vertex counting elsewhere.
module popcount_tree #(
   parameter  int WIDTH = 4,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] vec_in,
   output logic [CNT_W-1:0] cnt_out
);

   if (WIDTH == 1) begin : g_leaf
      assign cnt_out = vec_in;
   end else begin : g_node
      localparam int LO_W  = WIDTH / 2;
      localparam int HI_W  = WIDTH - LO_W;
      localparam int LO_CW = $clog2(LO_W + 1);
      localparam int HI_CW = $clog2(HI_W + 1);

      logic [LO_CW-1:0] cnt_lo;
      logic [HI_CW-1:0] cnt_hi;

      popcount_tree #(.WIDTH(LO_W)) u_lo (
         .vec_in  (vec_in[LO_W-1:0]),
         .cnt_out (cnt_lo)
      );

      popcount_tree #(.WIDTH(HI_W)) u_hi (
         .vec_in  (vec_in[WIDTH-1:LO_W]),
         .cnt_out (cnt_hi)
      );

      assign cnt_out = CNT_W'(cnt_lo) + CNT_W'(cnt_hi);
   end

endmodule

// File: rtl/iteration_sync_ctrl.sv
// Global iteration sequencer: gathers per-core end-of-scan, waits for pipeline drain,
// counts vertex updates and broadcasts one iteration-advance pulse to every core.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | waiting for start
// ST_RUN     | collecting per-core end bits into the sticky end mask
// ST_DRAIN   | all cores ended; waiting DRAIN_CYCLES quiet, idle cycles
// ST_ADVANCE | single cycle: iter_advance high, counters rolled over
// ST_DONE    | converged; outputs frozen until reset
module iteration_sync_ctrl
   import iteration_sync_ctrl_pkg::*;
#(
   parameter int CORE_NUM          = CORE_NUM_DEF,
   parameter int ITERATION_WIDTH   = ITERATION_WIDTH_DEF,
   parameter int MAX_ITERATION_NUM = MAX_ITERATION_NUM_DEF,
   parameter int UPD_CNT_WIDTH     = UPD_CNT_WIDTH_DEF,
   parameter int DRAIN_CYCLES      = DRAIN_CYCLES_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   iteration_sync_ctrl_if.slave       core_if,
   output logic [ITERATION_WIDTH-1:0] iteration_id,
   output logic [UPD_CNT_WIDTH-1:0]   last_upd_cnt,
   output logic                       busy,
   output logic                       converged
);

   localparam int POP_W  = $clog2(CORE_NUM + 1);
   localparam int IDLE_W = $clog2(DRAIN_CYCLES + 1);
   localparam int SUM_W  = UPD_CNT_WIDTH + 1;

   sync_state_e                state_q, state_d;
   logic [CORE_NUM-1:0]        end_mask_q, end_mask_d;
   logic [UPD_CNT_WIDTH-1:0]   upd_cnt_q, upd_cnt_d;
   logic [IDLE_W-1:0]          idle_cnt_q, idle_cnt_d;
   logic                       mask_gate_q, mask_gate_d;
   logic [CORE_NUM-1:0]        iter_advance_q, iter_advance_d;
   logic [ITERATION_WIDTH-1:0] iteration_id_q, iteration_id_d;
   logic [UPD_CNT_WIDTH-1:0]   last_upd_cnt_q, last_upd_cnt_d;
   logic                       busy_q, busy_d;
   logic                       converged_q, converged_d;

   logic [CORE_NUM-1:0]        upd_hit;
   logic [POP_W-1:0]           upd_pop;
   logic [SUM_W-1:0]           upd_sum;
   logic [UPD_CNT_WIDTH-1:0]   upd_cnt_inc;
   logic [CORE_NUM-1:0]        end_mask_run;
   logic [ITERATION_WIDTH-1:0] iteration_id_inc;
   logic                       drain_quiet;

   assign upd_hit = core_if.core_upd_valid & core_if.core_upd;

   popcount_tree #(.WIDTH(CORE_NUM)) u_upd_pop (
      .vec_in  (upd_hit),
      .cnt_out (upd_pop)
   );

   // Saturating accumulate: the carry out of the widened sum pins the count at all-ones.
   assign upd_sum          = {1'b0, upd_cnt_q} + SUM_W'(upd_pop);
   assign upd_cnt_inc      = upd_sum[UPD_CNT_WIDTH] ? '1 : upd_sum[UPD_CNT_WIDTH-1:0];
   assign end_mask_run     = mask_gate_q ? end_mask_q : (end_mask_q | core_if.core_iter_end);
   assign iteration_id_inc = iteration_id_q + 1'b1;
   assign drain_quiet      = (&core_if.pipe_idle) && !(|core_if.core_upd_valid);

   always_comb begin
      state_d        = state_q;
      end_mask_d     = end_mask_q;
      upd_cnt_d      = upd_cnt_q;
      idle_cnt_d     = idle_cnt_q;
      mask_gate_d    = 1'b0;
      iter_advance_d = '0;
      iteration_id_d = iteration_id_q;
      last_upd_cnt_d = last_upd_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_RUN;
               end_mask_d = '0;
               upd_cnt_d  = '0;
            end
         end
         ST_RUN: begin
            upd_cnt_d  = upd_cnt_inc;
            end_mask_d = end_mask_run;
            if (&end_mask_run) begin
               state_d    = ST_DRAIN;
               idle_cnt_d = IDLE_W'(DRAIN_CYCLES);
            end
         end
         ST_DRAIN: begin
            upd_cnt_d = upd_cnt_inc;
            if (!drain_quiet) begin
               idle_cnt_d = IDLE_W'(DRAIN_CYCLES);
            end else if (idle_cnt_q == IDLE_W'(1)) begin
               state_d        = ST_ADVANCE;
               iter_advance_d = '1;
            end else begin
               idle_cnt_d = idle_cnt_q - 1'b1;
            end
         end
         ST_ADVANCE: begin
            last_upd_cnt_d = upd_cnt_inc;
            iteration_id_d = iteration_id_inc;
            upd_cnt_d      = '0;
            end_mask_d     = '0;
            // Readers drop their end level one cycle late; ignore it for one RUN cycle.
            mask_gate_d    = 1'b1;
            if ((upd_cnt_q == '0) ||
                (iteration_id_inc == ITERATION_WIDTH'(MAX_ITERATION_NUM))) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d      = is_busy_state(state_d);
      converged_d = converged_q || (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         end_mask_q     <= '0;
         upd_cnt_q      <= '0;
         idle_cnt_q     <= '0;
         mask_gate_q    <= 1'b0;
         iter_advance_q <= '0;
         iteration_id_q <= '0;
         last_upd_cnt_q <= '0;
         busy_q         <= 1'b0;
         converged_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         end_mask_q     <= end_mask_d;
         upd_cnt_q      <= upd_cnt_d;
         idle_cnt_q     <= idle_cnt_d;
         mask_gate_q    <= mask_gate_d;
         iter_advance_q <= iter_advance_d;
         iteration_id_q <= iteration_id_d;
         last_upd_cnt_q <= last_upd_cnt_d;
         busy_q         <= busy_d;
         converged_q    <= converged_d;
      end
   end

   assign core_if.iter_advance = iter_advance_q;
   assign iteration_id         = iteration_id_q;
   assign last_upd_cnt         = last_upd_cnt_q;
   assign busy                 = busy_q;
   assign converged            = converged_q;

endmodule
